timer_responder: RTL and testbench
==================================

Name: timer_responder

Overview:
- Memory-mapped responder for the read-only, uncached 8-byte timer region at 0x3000_0000.
- The core's data-side bus initiator routes a request here once it has classified the address as the timer region.
- Holds a free-running 64-bit mtime counter advanced by a prescaler.
- Serves one outstanding request at a time over a valid/ready request/response handshake and returns an error response for illegal accesses.

Parameters:
- BASE_ADDR, 32'h3000_0000: region base; region spans BASE_ADDR..BASE_ADDR+7.
- PRESCALE, 1: clock cycles per mtime increment; legal range 1..65535.
- XLEN, 32: data/address width, taken from tcore_param.

Ports:
- clk_i  input  1  core clock
- rst_i  input  1  synchronous, active-high reset
- req_valid_i  input  1  request valid
- req_ready_o  output  1  request accepted when valid and ready are both high
- req_addr_i  input  XLEN  byte address
- req_we_i  input  1  1 = write, 0 = read
- req_wdata_i  input  XLEN  write data; ignored (region is read-only)
- rsp_valid_o  output  1  response valid
- rsp_ready_i  input  1  initiator accepts response
- rsp_rdata_o  output  XLEN  read data
- rsp_err_o  output  1  access fault

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i. All state updates on the rising edge of clk_i.
- Reset values: mtime=0, prescale_cnt=0, hi_shadow=0, state=IDLE, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0. req_ready_o=0 while rst_i is high.
- Prescaler:
  - prescale_cnt counts 0..PRESCALE-1 and wraps to 0.
  - mtime increments by 1 in the cycle prescale_cnt==PRESCALE-1.
  - With PRESCALE=1, mtime increments every cycle.
  - mtime wraps from 2^64-1 to 0 with no flag.
  - Counting continues in every state. It stops only during reset.
- FSM has two states, IDLE and RESP.
  - IDLE: req_ready_o=1. On req_valid_i, capture the request, compute the response, and go to RESP in the next cycle.
  - RESP: rsp_valid_o=1 and req_ready_o=0. rsp_rdata_o and rsp_err_o stay stable until rsp_ready_i=1. On that handshake, go to IDLE; rsp_valid_o falls next cycle.
  - No request is accepted in the same cycle as a response handshake. The minimum request-to-request spacing is 2 cycles.
  - Latency: rsp_valid_o rises exactly 1 cycle after request acceptance.
- Decode, evaluated at acceptance:
  - in_region = (req_addr_i & ~32'h7) == BASE_ADDR.
  - Offset 0, read: rdata = mtime[31:0] sampled in the accept cycle, i.e. the pre-increment value. In the same edge, hi_shadow <= mtime[63:32] from the same sample.
  - Offset 4, read: rdata = hi_shadow, not live mtime[63:32]. The low-then-high read sequence is therefore atomic.
  - Any write, an in-region offset other than 0 or 4, or !in_region: err=1, rdata=0, and hi_shadow is unchanged.
- Simultaneous events:
  - A read of offset 0 in the cycle mtime increments returns the old value.
  - The carry into the high word in that same cycle is not visible in hi_shadow.
- Reset mid-operation: a pending response is dropped (rsp_valid_o=0 next cycle) and the counter restarts at 0.
- A response stall of any length does not stop mtime.

Test Plan:
- Reset, then PRESCALE=1, read 0x3000_0000 at the 10th cycle after reset release -> rsp_valid_o 1 cycle later, rdata=9 (pre-increment sample), err=0.
- Force mtime to 0x0000_0001_FFFF_FFFF, read offset 0, then offset 4 a few cycles later -> rdata 0xFFFF_FFFF, then 0x0000_0001 (shadow value, not the live 0x0000_0002).
- Write 0x3000_0000 with data 0x1234 -> err=1, rdata=0; a subsequent read shows mtime unaffected.
- Read 0x3000_0002, 0x3000_0008 and 0x2000_0000 -> each returns err=1, rdata=0.
- Hold rsp_ready_i=0 for 20 cycles with req_valid_i held high -> req_ready_o=0 and rsp data stable throughout; the next request is accepted only after the response handshake plus 1 cycle.
- PRESCALE=4, read at cycles 0 and 16 -> values differ by exactly 4. Assert rst_i while in RESP -> rsp_valid_o=0 next cycle and mtime=0.

Source files
------------

// File: rtl/timer_responder.sv
// Read-only timer region responder: a free-running 64-bit mtime behind a
// prescaler, served one request at a time over a valid/ready bus.
module timer_responder #(
   parameter int XLEN = 32,
   parameter logic [XLEN-1:0] BASE_ADDR = XLEN'(32'h3000_0000),
   parameter int PRESCALE = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [XLEN-1:0] req_addr_i,
   input  logic            req_we_i,
   input  logic [XLEN-1:0] req_wdata_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [XLEN-1:0] rsp_rdata_o,
   output logic            rsp_err_o
);

   typedef enum logic {
      IDLE,
      RESP
   } state_t;

   localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

   state_t            state;
   state_t            state_next;
   logic [63:0]       mtime;
   logic [CNT_W-1:0]  prescale_cnt;
   logic [31:0]       hi_shadow;
   logic              tick;
   logic              accept;
   logic              in_region;
   logic [XLEN-1:0]   rdata_next;
   logic              err_next;
   logic              load_shadow;
   logic              unused_wdata;

   assign unused_wdata = ^req_wdata_i;

   assign tick      = (prescale_cnt == CNT_LAST);
   assign accept    = req_valid_i && req_ready_o;
   assign in_region = ((req_addr_i & ~XLEN'(7)) == BASE_ADDR);

   // mtime never pauses for the bus; only reset stops it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prescale_cnt <= '0;
         mtime        <= '0;
      end else if (tick) begin
         prescale_cnt <= '0;
         mtime        <= mtime + 64'd1;
      end else begin
         prescale_cnt <= prescale_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = RESP;
         RESP:    if (rsp_ready_i) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready_o = (state == IDLE) && !rst_i;
      rsp_valid_o = (state == RESP);
   end

   // The low-word read snapshots the high word so a low-then-high pair is atomic.
   always_comb begin
      rdata_next  = '0;
      err_next    = 1'b1;
      load_shadow = 1'b0;
      if (in_region && !req_we_i) begin
         if (req_addr_i[2:0] == 3'd0) begin
            rdata_next  = XLEN'(mtime[31:0]);
            err_next    = 1'b0;
            load_shadow = 1'b1;
         end else if (req_addr_i[2:0] == 3'd4) begin
            rdata_next = XLEN'(hi_shadow);
            err_next   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rsp_rdata_o <= '0;
         rsp_err_o   <= 1'b0;
         hi_shadow   <= '0;
      end else if (accept) begin
         rsp_rdata_o <= rdata_next;
         rsp_err_o   <= err_next;
         if (load_shadow) begin
            hi_shadow <= mtime[63:32];
         end
      end
   end

endmodule

// File: tb/tb_timer_responder.sv
// Scoreboard bench for timer_responder: directed requests push expected
// responses, a monitor pops and compares on each response handshake.
module tb_timer_responder;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
   logic [31:0] req_addr, req_wdata, rsp_rdata;
   logic        req_valid4, req_ready4, req_we4, rsp_valid4, rsp_ready4, rsp_err4;
   logic [31:0] req_addr4, req_wdata4, rsp_rdata4;

   exp_t        q0[$];
   exp_t        q4[$];
   int          total = 0;
   int          bad = 0;
   logic [63:0] tb_time;
   logic [31:0] shadow_m;
   logic [31:0] exp_d;

   always #5 clk = ~clk;

   timer_responder #(.XLEN(32), .BASE_ADDR(32'h3000_0000), .PRESCALE(1)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
      .req_we_i(req_we), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
   );

   timer_responder #(.XLEN(32), .BASE_ADDR(32'h3000_0000), .PRESCALE(4)) dut4 (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid4), .req_ready_o(req_ready4), .req_addr_i(req_addr4),
      .req_we_i(req_we4), .req_wdata_i(req_wdata4),
      .rsp_valid_o(rsp_valid4), .rsp_ready_i(rsp_ready4),
      .rsp_rdata_o(rsp_rdata4), .rsp_err_o(rsp_err4)
   );

   // Reference time for the PRESCALE=1 instance: cycles since reset release.
   always @(posedge clk) begin
      if (rst) tb_time <= 64'd0;
      else     tb_time <= tb_time + 64'd1;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, want);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      #2;
      if (rsp_valid && rsp_ready) begin
         if (q0.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_rsp: got data 0x%0h, required no response", rsp_rdata);
         end else begin
            e = q0.pop_front();
            checkOutput("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.data});
            checkOutput("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
         end
      end
      if (rsp_valid4 && rsp_ready4) begin
         if (q4.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_rsp4: got data 0x%0h, required no response", rsp_rdata4);
         end else begin
            e = q4.pop_front();
            checkOutput("rsp4_rdata", {32'd0, rsp_rdata4}, {32'd0, e.data});
            checkOutput("rsp4_err", {63'd0, rsp_err4}, {63'd0, e.err});
         end
      end
   end

   task automatic modelExpect(input logic [31:0] addr, input logic we, output exp_t e);
      e.data = 32'd0;
      e.err  = 1'b1;
      if (((addr & ~32'h7) == 32'h3000_0000) && !we) begin
         if (addr[2:0] == 3'd0) begin
            e.data   = tb_time[31:0];
            e.err    = 1'b0;
            shadow_m = tb_time[63:32];
         end else if (addr[2:0] == 3'd4) begin
            e.data = shadow_m;
            e.err  = 1'b0;
         end
      end
   endtask

   // Call at a negedge; returns one negedge after acceptance (+1) with valid dropped.
   task automatic applyStimulus(input bit sel, input logic [31:0] addr, input logic we,
                                input bit use_model, input logic [31:0] want_data,
                                input logic want_err, output logic [31:0] pushed);
      exp_t e;
      bit   ok = 0;
      if (sel) begin
         req_valid4 = 1'b1; req_addr4 = addr; req_we4 = we; req_wdata4 = 32'h1234;
      end else begin
         req_valid = 1'b1; req_addr = addr; req_we = we; req_wdata = 32'h1234;
      end
      for (int w = 0; w < 50 && !ok; w++) begin
         #1;
         if (sel ? req_ready4 : req_ready) ok = 1;
         else @(negedge clk);
      end
      if (!ok) begin
         total++;
         bad++;
         $display("[TB] FAIL accept_timeout: got ready 0, required 1 for addr 0x%0h", addr);
      end else begin
         if (use_model) modelExpect(addr, we, e);
         else begin
            e.data = want_data;
            e.err  = want_err;
         end
         pushed = e.data;
         if (sel) q4.push_back(e);
         else     q0.push_back(e);
      end
      @(negedge clk);
      if (sel) req_valid4 = 1'b0;
      else     req_valid  = 1'b0;
      #1;
      if (ok) checkOutput("rsp_latency", {63'd0, sel ? rsp_valid4 : rsp_valid}, 64'd1);
   endtask

   initial begin
      exp_t e;
      bit   drained;
      rst = 1'b1;
      req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_wdata = '0; rsp_ready = 1'b1;
      req_valid4 = 1'b0; req_addr4 = '0; req_we4 = 1'b0; req_wdata4 = '0; rsp_ready4 = 1'b1;
      shadow_m = '0;
      exp_d = '0;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset_req_ready", {63'd0, req_ready}, 64'd0);
      checkOutput("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      checkOutput("reset_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
      checkOutput("reset_rsp_err", {63'd0, rsp_err}, 64'd0);

      @(negedge clk);
      rst = 1'b0;
      repeat (9) @(negedge clk);
      applyStimulus(0, 32'h3000_0000, 1'b0, 0, 32'd9, 1'b0, exp_d);

      @(negedge clk);
      applyStimulus(0, 32'h3000_0000, 1'b1, 0, 32'd0, 1'b1, exp_d);
      @(negedge clk);
      applyStimulus(0, 32'h3000_0000, 1'b0, 1, 32'd0, 1'b0, exp_d);

      @(negedge clk);
      applyStimulus(0, 32'h3000_0002, 1'b0, 0, 32'd0, 1'b1, exp_d);
      @(negedge clk);
      applyStimulus(0, 32'h3000_0008, 1'b0, 0, 32'd0, 1'b1, exp_d);
      @(negedge clk);
      applyStimulus(0, 32'h2000_0000, 1'b0, 0, 32'd0, 1'b1, exp_d);

      // Stalled response with a second request pressing behind it.
      @(negedge clk);
      rsp_ready = 1'b0;
      applyStimulus(0, 32'h3000_0000, 1'b0, 1, 32'd0, 1'b0, exp_d);
      req_valid = 1'b1; req_addr = 32'h3000_0000; req_we = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         checkOutput("stall_req_ready", {63'd0, req_ready}, 64'd0);
         checkOutput("stall_rsp_valid", {63'd0, rsp_valid}, 64'd1);
         checkOutput("stall_rsp_rdata", {32'd0, rsp_rdata}, {32'd0, exp_d});
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      #1;
      checkOutput("ready_at_handshake", {63'd0, req_ready}, 64'd0);
      @(negedge clk);
      #1;
      checkOutput("ready_after_handshake", {63'd0, req_ready}, 64'd1);
      checkOutput("valid_after_handshake", {63'd0, rsp_valid}, 64'd0);
      modelExpect(32'h3000_0000, 1'b0, e);
      q0.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      checkOutput("held_req_latency", {63'd0, rsp_valid}, 64'd1);

      // High-word read must return the shadow, not the carried live value.
      repeat (2) @(negedge clk);
      force dut.mtime = 64'h0000_0001_FFFF_FFFF;
      applyStimulus(0, 32'h3000_0000, 1'b0, 0, 32'hFFFF_FFFF, 1'b0, exp_d);
      release dut.mtime;
      repeat (3) @(negedge clk);
      applyStimulus(0, 32'h3000_0004, 1'b0, 0, 32'h0000_0001, 1'b0, exp_d);

      // Reset while a response is pending.
      @(negedge clk);
      rsp_ready = 1'b0;
      applyStimulus(0, 32'h3000_0000, 1'b0, 0, 32'd0, 1'b0, exp_d);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("ready_during_reset", {63'd0, req_ready}, 64'd0);
      @(negedge clk);
      #1;
      checkOutput("valid_after_reset", {63'd0, rsp_valid}, 64'd0);
      q0.delete();
      rsp_ready = 1'b1;
      rst = 1'b0;
      applyStimulus(0, 32'h3000_0000, 1'b0, 0, 32'd0, 1'b0, exp_d);

      // PRESCALE=4 instance: reads 16 cycles apart differ by 4.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1, 32'h3000_0000, 1'b0, 0, 32'd0, 1'b0, exp_d);
      repeat (15) @(negedge clk);
      applyStimulus(1, 32'h3000_0000, 1'b0, 0, 32'd4, 1'b0, exp_d);

      drained = 0;
      for (int w = 0; w < 20 && !drained; w++) begin
         @(negedge clk);
         #3;
         if (q0.size() == 0 && q4.size() == 0) drained = 1;
      end
      if (!drained) begin
         total++;
         bad++;
         $display("[TB] FAIL drain: got %0d pending responses, required 0", q0.size() + q4.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
